multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_pkg.sv | 82 ++++++++
 rtl/multicycle_control_if.sv | 37 +++
 rtl/multicycle_control_mem_wait_timer.sv | 30 +++
 rtl/multicycle_control.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes,
// immediate formats and datapath mux selects.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_EXEC_R   = 4'd6,
    ST_EXEC_I   = 4'd7,
    ST_ALU_WB   = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JAL      = 4'd10,
    ST_LUI      = 4'd11,
    ST_FAULT    = 4'd12
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [2:0] {
    IMM_R = 3'd0,
    IMM_I = 3'd1,
    IMM_S = 3'd2,
    IMM_B = 3'd3,
    IMM_U = 3'd4,
    IMM_J = 3'd5
  } imm_type_t;

  typedef enum logic [1:0] {
    SRC_A_PC     = 2'd0,
    SRC_A_OLD_PC = 2'd1,
    SRC_A_RS1    = 2'd2,
    SRC_A_ZERO   = 2'd3
  } src_a_t;

  typedef enum logic [1:0] {
    SRC_B_RS2  = 2'd0,
    SRC_B_IMM  = 2'd1,
    SRC_B_FOUR = 2'd2
  } src_b_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_FUNCT = 2'd2
  } alu_op_t;

  typedef enum logic [1:0] {
    RES_ALU     = 2'd0,
    RES_ALU_OUT = 2'd1,
    RES_MEM     = 2'd2
  } result_src_t;

  // States that hold a memory request open until mem_ready_i.
  function automatic logic is_request_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

  // DECODE dispatch; unknown opcodes fall back to FETCH as a NOP.
  function automatic state_t dispatch(input logic [6:0] opcode);
    case (opcode)
      OP_LOAD, OP_STORE: return ST_MEM_ADDR;
      OP_REG:            return ST_EXEC_R;
      OP_IMM, OP_JALR:   return ST_EXEC_I;
      OP_BRANCH:         return ST_BRANCH;
      OP_JAL:            return ST_JAL;
      OP_LUI:            return ST_LUI;
      default:           return ST_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Instruction fields, memory handshake and datapath control strobes between
// the multicycle controller (master) and the datapath (slave).
interface multicycle_control_if;

  logic [6:0] opcode_i;
  logic [2:0] funct3_i;
  logic       zero_i;
  logic       mem_ready_i;

  logic       mem_req_o;
  logic       mem_write_o;
  logic       ir_write_o;
  logic       pc_write_o;
  logic       reg_write_o;
  logic [2:0] imm_type_o;
  logic [1:0] alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic [1:0] alu_op_o;
  logic [1:0] result_src_o;
  logic [3:0] state_o;
  logic       fault_o;

  modport master (
    input  opcode_i, funct3_i, zero_i, mem_ready_i,
    output mem_req_o, mem_write_o, ir_write_o, pc_write_o, reg_write_o,
           imm_type_o, alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o,
           state_o, fault_o
  );

  modport slave (
    output opcode_i, funct3_i, zero_i, mem_ready_i,
    input  mem_req_o, mem_write_o, ir_write_o, pc_write_o, reg_write_o,
           imm_type_o, alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o,
           state_o, fault_o
  );

endinterface

// File: rtl/multicycle_control_mem_wait_timer.sv
// Memory wait counter: counts stalled request cycles and flags the cycle in
// which the count would reach the limit without a completion strobe.
module mem_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en,
  output logic expire
);

  localparam int W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [W-1:0] LAST = W'(MAX_WAIT - 1);

  logic [W-1:0] count;

  // Any cycle that is not a stalled request (no request, or ready seen)
  // clears the count, so each request state starts fresh on entry.
  always_ff @(posedge clk) begin
    if (reset || !count_en) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // A ready strobe in the final cycle drops count_en, so it wins over timeout.
  assign expire = count_en && (count == LAST);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V style control FSM with a memory wait watchdog.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);

  state_t state;
  logic   mem_req;
  logic   timeout;
  logic   is_link;

  assign mem_req = is_request_state(state);
  assign is_link = (bus.opcode_i == OP_JAL) || (bus.opcode_i == OP_JALR);

  mem_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait (
    .clk      (clk),
    .reset    (reset),
    .count_en (mem_req && !bus.mem_ready_i),
    .expire   (timeout)
  );

  // State register and next-state logic.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_FETCH;
    end else begin
      case (state)
        ST_FETCH: begin
          if (bus.mem_ready_i)  state <= ST_DECODE;
          else if (timeout)     state <= ST_FAULT;
        end
        ST_DECODE:   state <= dispatch(bus.opcode_i);
        ST_MEM_ADDR: state <= (bus.opcode_i == OP_STORE) ? ST_MEM_WR : ST_MEM_RD;
        ST_MEM_RD: begin
          if (bus.mem_ready_i)  state <= ST_MEM_WB;
          else if (timeout)     state <= ST_FAULT;
        end
        ST_MEM_WR: begin
          if (bus.mem_ready_i)  state <= ST_FETCH;
          else if (timeout)     state <= ST_FAULT;
        end
        ST_MEM_WB, ST_ALU_WB, ST_BRANCH:       state <= ST_FETCH;
        ST_EXEC_R, ST_EXEC_I, ST_JAL, ST_LUI:  state <= ST_ALU_WB;
        ST_FAULT:                              state <= ST_FAULT;
        default:                               state <= ST_FETCH;
      endcase
    end
  end

  // Output decode from the state register; reset masks everything so an
  // in-flight store cannot strobe in the reset cycle.
  always_comb begin
    bus.mem_req_o    = 1'b0;
    bus.mem_write_o  = 1'b0;
    bus.ir_write_o   = 1'b0;
    bus.pc_write_o   = 1'b0;
    bus.reg_write_o  = 1'b0;
    bus.imm_type_o   = IMM_R;
    bus.alu_src_a_o  = SRC_A_PC;
    bus.alu_src_b_o  = SRC_B_RS2;
    bus.alu_op_o     = ALU_ADD;
    bus.result_src_o = RES_ALU;
    bus.state_o      = ST_FETCH;
    bus.fault_o      = 1'b0;
    if (!reset) begin
      bus.state_o = state;
      case (state)
        ST_FETCH: begin
          bus.mem_req_o   = 1'b1;
          bus.alu_src_a_o = SRC_A_PC;
          bus.alu_src_b_o = SRC_B_FOUR;
          bus.ir_write_o  = bus.mem_ready_i;
          bus.pc_write_o  = bus.mem_ready_i;
        end
        ST_DECODE: begin
          bus.alu_src_a_o = SRC_A_OLD_PC;
          bus.alu_src_b_o = SRC_B_IMM;
          bus.imm_type_o  = IMM_B;
        end
        ST_MEM_ADDR: begin
          bus.alu_src_a_o = SRC_A_RS1;
          bus.alu_src_b_o = SRC_B_IMM;
          bus.imm_type_o  = (bus.opcode_i == OP_STORE) ? IMM_S : IMM_I;
        end
        ST_MEM_RD: begin
          bus.mem_req_o = 1'b1;
        end
        ST_MEM_WR: begin
          bus.mem_req_o   = 1'b1;
          bus.mem_write_o = 1'b1;
        end
        ST_MEM_WB: begin
          bus.reg_write_o  = 1'b1;
          bus.result_src_o = RES_MEM;
        end
        ST_EXEC_R: begin
          bus.alu_src_a_o = SRC_A_RS1;
          bus.alu_src_b_o = SRC_B_RS2;
          bus.alu_op_o    = ALU_FUNCT;
        end
        ST_EXEC_I: begin
          bus.alu_src_a_o = SRC_A_RS1;
          bus.alu_src_b_o = SRC_B_IMM;
          bus.imm_type_o  = IMM_I;
          if (bus.opcode_i == OP_JALR) begin
            // JALR: rs1+imm goes straight into PC this cycle.
            bus.alu_op_o     = ALU_ADD;
            bus.pc_write_o   = 1'b1;
            bus.result_src_o = RES_ALU;
          end else begin
            bus.alu_op_o = ALU_FUNCT;
          end
        end
        ST_ALU_WB: begin
          bus.reg_write_o = 1'b1;
          if (is_link) begin
            // Jumps link oldPC+4: ALUOut holds the target, not the return
            // address, so recompute it on the ALU and write it directly.
            bus.alu_src_a_o  = SRC_A_OLD_PC;
            bus.alu_src_b_o  = SRC_B_FOUR;
            bus.alu_op_o     = ALU_ADD;
            bus.result_src_o = RES_ALU;
          end else begin
            bus.result_src_o = RES_ALU_OUT;
          end
        end
        ST_BRANCH: begin
          bus.alu_src_a_o  = SRC_A_RS1;
          bus.alu_src_b_o  = SRC_B_RS2;
          bus.alu_op_o     = ALU_SUB;
          bus.result_src_o = RES_ALU_OUT;
          bus.pc_write_o   = bus.zero_i ^ bus.funct3_i[0];
        end
        ST_JAL: begin
          bus.pc_write_o   = 1'b1;
          bus.result_src_o = RES_ALU_OUT;
          bus.imm_type_o   = IMM_J;
        end
        ST_LUI: begin
          bus.imm_type_o  = IMM_U;
          bus.alu_src_a_o = SRC_A_ZERO;
          bus.alu_src_b_o = SRC_B_IMM;
          bus.alu_op_o    = ALU_ADD;
        end
        ST_FAULT: begin
          bus.fault_o = 1'b1;
        end
        default: begin
          bus.state_o = ST_FETCH;
        end
      endcase
    end
  end

endmodule
